// File: rtl/multiword_add_sequencer_if.sv
// Handshake bundle for multiword_add_sequencer: operation request side and result side.
// The ovf signal exists only when ADDSEQ_OVF_EN is defined.
interface multiword_add_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef ADDSEQ_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-cycle wide adder: WIDTH-bit operands added CHUNK bits per clock, LSW first,
// through one ripple_carry_adder. Optional signed overflow output under ADDSEQ_OVF_EN.

module ripple_carry_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] carry_s;

  // Bit-serial carry chain across the word.
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    carry_s[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry_s[N];
endmodule

module multiword_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiword_add_sequencer_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("multiword_add_sequencer: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef ADDSEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [OW-1:0]    off_s;
  logic [CHUNK-1:0] a_word_s;
  logic [CHUNK-1:0] b_word_s;
  logic [CHUNK-1:0] add_sum_s;
  logic             add_cout_s;

  // Bit offset of the word currently being processed.
  assign off_s    = OW'(int'(idx_q) * CHUNK);
  assign a_word_s = a_q[off_s +: CHUNK];
  assign b_word_s = b_q[off_s +: CHUNK];

  ripple_carry_adder #(.N(CHUNK)) u_rca (
    .a    (a_word_s),
    .b    (b_word_s),
    .cin  (carry_q),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef ADDSEQ_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          carry_d    = bus.cin;
          idx_d      = '0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[off_s +: CHUNK] = add_sum_s;
        carry_d               = add_cout_s;
        if (idx_q == LAST_IDX) begin
          // Carry into the MSB is recovered from the MSB sum bit and operand MSBs.
          cout_d      = add_cout_s;
`ifdef ADDSEQ_OVF_EN
          ovf_d       = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_sum_s[CHUNK-1]) ^ add_cout_s;
`endif
          idx_d       = '0;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d       = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        idx_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ADDSEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ADDSEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;
`ifdef ADDSEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer: directed corner cases plus random
// operations against an arithmetic reference model; ovf checks under ADDSEQ_OVF_EN.
module tb_multiword_add_sequencer;
  localparam int W   = 32;
  localparam int C   = 8;
  localparam int NCH = W / C;

  logic clk;
  logic rst_n;
  int   checks_cnt;
  int   errors_cnt;

  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  multiword_add_sequencer_if #(.WIDTH(W)) bus ();

  multiword_add_sequencer #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W+31:0] v;
    v = '0;
    for (int i = 0; i < W; i += 32) v = (v << 32) | {{W{1'b0}}, $urandom()};
    return v[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full operation: accept, wait for result, optional backpressure, output handshake.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input int hold);
    logic [W:0] full;
    logic       exp_ovf;
    int         cyc;
    full    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    exp_ovf = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    check_val("in_ready_idle", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = cv;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = rand_word();
    bus.b        = rand_word();
    bus.cin      = 1'($urandom_range(0, 1));
    check_val("in_ready_run", bus.in_ready, 1'b0);
    check_val("busy_run", bus.busy, 1'b1);
    cyc = 0;
    while (!bus.out_valid && cyc < NCH + 20) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check_val("latency", cyc, NCH);
    check_val("sum", bus.sum, full[W-1:0]);
    check_val("cout", bus.cout, full[W]);
`ifdef ADDSEQ_OVF_EN
    check_val("ovf", bus.ovf, exp_ovf);
    last_ovf = bus.ovf;
`else
    last_ovf = exp_ovf;
`endif
    last_sum  = bus.sum;
    last_cout = bus.cout;
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = rand_word();
      tick();
      check_val("bp_valid", bus.out_valid, 1'b1);
      check_val("bp_sum", bus.sum, full[W-1:0]);
      check_val("bp_cout", bus.cout, full[W]);
      check_val("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_val("post_valid", bus.out_valid, 1'b0);
    check_val("post_in_ready", bus.in_ready, 1'b1);
    check_val("post_busy", bus.busy, 1'b0);
    check_val("post_sum_held", bus.sum, full[W-1:0]);
  endtask

  initial begin
    logic seen_valid;
    checks_cnt    = 0;
    errors_cnt    = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check_val("rst_in_ready", bus.in_ready, 1'b1);
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_sum", bus.sum, '0);
    check_val("rst_cout", bus.cout, 1'b0);
    check_val("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    check_val("dir_wrap_sum", last_sum, 32'h0000_0000);
    check_val("dir_wrap_cout", last_cout, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
    check_val("dir_ripple_sum", last_sum, 32'h0000_0000);
    check_val("dir_ripple_cout", last_cout, 1'b1);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
    check_val("dir_plain_sum", last_sum, 32'h2345_6789);
    check_val("dir_plain_cout", last_cout, 1'b0);
    run_op(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 10);

    // Reset two cycles into RUN: outputs return to reset values at once, no result follows.
    bus.in_valid = 1'b1;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0101_0101;
    bus.cin      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_in_ready", bus.in_ready, 1'b1);
    check_val("mid_rst_out_valid", bus.out_valid, 1'b0);
    check_val("mid_rst_sum", bus.sum, '0);
    check_val("mid_rst_cout", bus.cout, 1'b0);
    check_val("mid_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_valid = seen_valid | bus.out_valid;
    end
    check_val("mid_rst_no_valid", seen_valid, 1'b0);
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);
    check_val("after_rst_sum", last_sum, 32'h0001_0000);

`ifdef ADDSEQ_OVF_EN
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    check_val("ovf_pos", last_ovf, 1'b1);
    check_val("ovf_pos_cout", last_cout, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    check_val("ovf_none", last_ovf, 1'b0);
    check_val("ovf_none_cout", last_cout, 1'b1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    check_val("ovf_neg", last_ovf, 1'b1);
    check_val("ovf_neg_cout", last_cout, 1'b1);
    check_val("ovf_neg_sum", last_sum, 32'h0000_0000);
`endif

    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      av = rand_word();
      bv = rand_word();
      case ($urandom_range(0, 5))
        0: av = '1;
        1: bv = ~av;
        2: bv = '0;
        default: av = av;
      endcase
      run_op(av, bv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      bus.out_ready = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
